// File: rtl/gate_window_sequencer.sv
// Gate window sequencer: drives the clear/snapshot strobes of the gated pulse
// counter to form back-to-back windows of programmable length. It captures
// each snapshot and presents it as a valid/ready result stream carrying a
// sequence number, a saturation flag and a sticky overrun flag.
//
// Result handshake: a transfer happens on every rising clk edge where
// res_valid && res_ready. While res_valid=1 and res_ready=0 the result fields
// hold stable. A new capture that meets res_valid && !res_ready is dropped:
// the held result is kept and overrun is set.
module gate_window_sequencer #(
   parameter int W_CTR  = 8,
   parameter int W_GATE = 32,
   parameter int W_SEQ  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [W_GATE-1:0] gate_len,
   input  logic [W_CTR-1:0]  ctr_val,
   output logic              ctr_rst,
   output logic              ctr_smp,
   output logic [W_CTR-1:0]  res_data,
   output logic              res_sat,
   output logic [W_SEQ-1:0]  res_seq,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              overrun,
   input  logic              clr_ovr,
   output logic              busy,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PRIME    = 2'd1,
      S_GATE     = 2'd2,
      S_BOUNDARY = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [W_GATE-1:0]  glen_q, glen_d;
   logic [W_GATE-1:0]  gcnt_q, gcnt_d;
   logic [W_GATE-1:0]  gate_eff;
   logic               cap_q;
   logic [W_SEQ-1:0]   seq_q, seq_d;
   logic [W_CTR-1:0]   data_q, data_d;
   logic               sat_q, sat_d;
   logic [W_SEQ-1:0]   rseq_q, rseq_d;
   logic               valid_q, valid_d;
   logic               ovr_q, ovr_d;
   logic               drop;

   // A zero gate length would give an empty window; run it as one cycle.
   assign gate_eff = (gate_len == '0) ? W_GATE'(1) : gate_len;

   // Next-state logic: window length is latched when a window sequence starts
   // and again on every boundary, so mid-window changes apply to the next one.
   always_comb begin
      state_d = state_q;
      glen_d  = glen_q;
      gcnt_d  = gcnt_q;
      case (state_q)
         S_IDLE: begin
            if (en) begin
               state_d = S_PRIME;
               glen_d  = gate_eff;
            end
         end
         S_PRIME: begin
            state_d = S_GATE;
            gcnt_d  = W_GATE'(1);
         end
         S_GATE: begin
            if (gcnt_q >= glen_q) state_d = S_BOUNDARY;
            else                  gcnt_d  = gcnt_q + W_GATE'(1);
         end
         S_BOUNDARY: begin
            glen_d  = gate_eff;
            gcnt_d  = W_GATE'(1);
            state_d = en ? S_GATE : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with the gate cycle counter and latched length.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         glen_q  <= W_GATE'(1);
         gcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         glen_q  <= glen_d;
         gcnt_q  <= gcnt_d;
      end
   end

   // Counter strobes decode straight from the state; rst also clears the counter.
   assign ctr_rst = rst | (state_q == S_PRIME) | (state_q == S_BOUNDARY);
   assign ctr_smp = ~rst & (state_q == S_BOUNDARY);

   // Result path: capture the snapshot the cycle after a boundary.
   always_comb begin
      data_d  = data_q;
      sat_d   = sat_q;
      rseq_d  = rseq_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      seq_d   = seq_q;
      drop    = 1'b0;
      if (cap_q) begin
         if (!valid_q || res_ready) begin
            data_d  = ctr_val;
            sat_d   = (ctr_val == {W_CTR{1'b1}});
            rseq_d  = seq_q;
            valid_d = 1'b1;
         end else begin
            drop = 1'b1;
         end
         // Dropped windows still consume a sequence number so gaps show.
         seq_d = seq_q + W_SEQ'(1);
      end else if (valid_q && res_ready) begin
         valid_d = 1'b0;
      end
      if (state_q == S_IDLE && en) seq_d = '0;
      if (drop)         ovr_d = 1'b1;
      else if (clr_ovr) ovr_d = 1'b0;
   end

   // Result registers and the capture-pending flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_q   <= 1'b0;
         seq_q   <= '0;
         data_q  <= '0;
         sat_q   <= 1'b0;
         rseq_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         cap_q   <= (state_q == S_BOUNDARY);
         seq_q   <= seq_d;
         data_q  <= data_d;
         sat_q   <= sat_d;
         rseq_q  <= rseq_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign res_data    = data_q;
   assign res_sat     = sat_q;
   assign res_seq     = rseq_q;
   assign res_valid   = valid_q;
   assign overrun     = ovr_q;
   assign busy        = (state_q != S_IDLE) | cap_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gate_window_sequencer.sv
// Bench for gate_window_sequencer with a behavioural gated pulse counter.
module tb_gate_window_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [31:0] gate_len = '0;
   logic [7:0]  ctr_val;
   logic        ctr_rst, ctr_smp;
   logic [7:0]  res_data;
   logic        res_sat;
   logic [15:0] res_seq;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic        overrun;
   logic        clr_ovr = 1'b0;
   logic        busy;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   logic [24:0] exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   gate_window_sequencer #(.W_CTR(8), .W_GATE(32), .W_SEQ(16)) dut (
      .clk(clk), .rst(rst), .en(en), .gate_len(gate_len), .ctr_val(ctr_val),
      .ctr_rst(ctr_rst), .ctr_smp(ctr_smp), .res_data(res_data), .res_sat(res_sat),
      .res_seq(res_seq), .res_valid(res_valid), .res_ready(res_ready),
      .overrun(overrun), .clr_ovr(clr_ovr), .busy(busy), .dbg_state_o(dbg_state)
   );

   // gated pulse counter, input tied high
   logic [7:0] cnt_q  = '0;
   logic [7:0] snap_q = '0;
   always @(posedge clk) begin
      if (ctr_rst) cnt_q <= '0;
      else if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
      if (ctr_smp) snap_q <= cnt_q;
   end
   assign ctr_val = snap_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [24:0] pack(input logic [7:0] d, input logic s, input logic [15:0] q);
      return {s, q, d};
   endfunction

   // scoreboard monitor: compare every accepted result, and stability while stalled
   logic        prev_stall = 1'b0;
   logic [24:0] prev_word  = '0;
   always @(negedge clk) begin
      logic [24:0] got;
      got = {res_sat, res_seq, res_data};
      if (!rst && prev_stall && res_valid) check("stall_hold", 32'(got), 32'(prev_word));
      if (!rst && res_valid && res_ready) begin
         if (exp_q.size() == 0) check("unexpected_result", 32'(got), 32'hFFFF_FFFF);
         else check("result", 32'(got), 32'(exp_q.pop_front()));
      end
      prev_stall = !rst && res_valid && !res_ready;
      prev_word  = got;
   end

   // driver: run K windows of length L, checking strobe/busy/valid timing per cycle
   task automatic run(input int L, input int K, input int ready_from, input int drop_t,
                      output int first_ovr);
      int l1, p, bk;
      bit is_b, exp_valid;
      l1 = (L == 0) ? 1 : L;
      p  = l1 + 1;
      bk = 1 + K * p;
      first_ovr = 0;
      gate_len  = L;
      en        = 1'b1;
      res_ready = (ready_from == 0);
      for (int t = 1; t <= bk + 3; t++) begin
         @(posedge clk); #1;
         res_ready = (ready_from == 0) || (t >= ready_from);
         if (t == drop_t || t == bk) en = 1'b0;
         is_b = (t >= p + 1) && ((t - 1) % p == 0) && ((t - 1) / p <= K);
         check($sformatf("ctr_rst t=%0d", t), 32'(ctr_rst), 32'((t == 1) || is_b));
         check($sformatf("ctr_smp t=%0d", t), 32'(ctr_smp), 32'(is_b));
         check($sformatf("busy t=%0d", t), 32'(busy), 32'(t <= bk + 1));
         if (ready_from == 0) begin
            exp_valid = (t >= p + 3) && ((t - 3) % p == 0) && ((t - 3) / p <= K);
            check($sformatf("res_valid t=%0d", t), 32'(res_valid), 32'(exp_valid));
         end
         if (overrun && first_ovr == 0) first_ovr = t;
      end
      check("end_state_idle", 32'(dbg_state), 32'd0);
      check("end_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int fo;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst ctr_rst", 32'(ctr_rst), 32'd1);
      check("rst ctr_smp", 32'(ctr_smp), 32'd0);
      check("rst res_valid", 32'(res_valid), 32'd0);
      check("rst res_data", 32'(res_data), 32'd0);
      check("rst res_seq", 32'(res_seq), 32'd0);
      check("rst overrun", 32'(overrun), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle ctr_rst", 32'(ctr_rst), 32'd0);

      // gate_len=10: count 10 every 11 cycles, seq 0..3
      for (int k = 0; k < 4; k++) exp_q.push_back(pack(8'd10, 1'b0, 16'(k)));
      run(10, 4, 0, 0, fo);

      // gate_len=300: counter saturates at 255
      for (int k = 0; k < 2; k++) exp_q.push_back(pack(8'd255, 1'b1, 16'(k)));
      run(300, 2, 0, 0, fo);

      // gate_len=0 treated as 1: count 1 every 2 cycles
      for (int k = 0; k < 4; k++) exp_q.push_back(pack(8'd1, 1'b0, 16'(k)));
      run(0, 4, 0, 0, fo);

      // stalled downstream: seq0 held, seq1/seq2 dropped, then seq3 accepted
      exp_q.push_back(pack(8'd5, 1'b0, 16'd0));
      exp_q.push_back(pack(8'd5, 1'b0, 16'd3));
      run(5, 4, 21, 0, fo);
      check("overrun first cycle", 32'(fo), 32'd15);
      check("overrun sticky", 32'(overrun), 32'd1);
      clr_ovr = 1'b1;
      @(posedge clk); #1;
      clr_ovr = 1'b0;
      check("overrun cleared", 32'(overrun), 32'd0);

      // en dropped mid-gate: window finishes, one result
      exp_q.push_back(pack(8'd8, 1'b0, 16'd0));
      run(8, 1, 0, 5, fo);
      // restart: sequence number starts over
      exp_q.push_back(pack(8'd8, 1'b0, 16'd0));
      exp_q.push_back(pack(8'd8, 1'b0, 16'd1));
      run(8, 2, 0, 0, fo);

      // reset mid-gate while a result is held
      gate_len  = 8;
      en        = 1'b1;
      res_ready = 1'b0;
      for (int t = 1; t <= 15; t++) begin
         @(posedge clk); #1;
      end
      check("pre-rst res_valid", 32'(res_valid), 32'd1);
      check("pre-rst state gate", 32'(dbg_state), 32'd2);
      rst = 1'b1;
      en  = 1'b0;
      #1;
      check("rst-mid ctr_rst", 32'(ctr_rst), 32'd1);
      check("rst-mid ctr_smp", 32'(ctr_smp), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("post-rst res_valid", 32'(res_valid), 32'd0);
      check("post-rst res_data", 32'(res_data), 32'd0);
      check("post-rst res_sat", 32'(res_sat), 32'd0);
      check("post-rst res_seq", 32'(res_seq), 32'd0);
      check("post-rst overrun", 32'(overrun), 32'd0);
      check("post-rst busy", 32'(busy), 32'd0);
      check("post-rst state", 32'(dbg_state), 32'd0);
      res_ready = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk); #1;
         check($sformatf("no result after rst t=%0d", t), 32'(res_valid), 32'd0);
      end

      check("scoreboard empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gate_window_sequencer.md
Name: gate_window_sequencer

Overview:
- Timing controller placed directly beside the gated pulse counter (synchronous counter: clears on its rst, snapshots count on smp, saturates at all-ones).
- Generates the counter's clear/snapshot strobes to define back-to-back gate windows of programmable length.
- Captures each snapshot and presents it downstream as a valid/ready result stream, with sequence number, saturation flag and sticky overrun flag.
- Forms the timebase of the frequency-measurement path.

Parameters:
- W_CTR, 8, width of counter value (must match counter).
- W_GATE, 32, width of gate length in clk cycles.
- W_SEQ, 16, width of result sequence number.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request; level-sensitive.
- gate_len  in  W_GATE  gate window length in clk cycles; 0 treated as 1.
- ctr_val  in  W_CTR  counter snapshot output.
- ctr_rst  out  1  counter clear strobe.
- ctr_smp  out  1  counter snapshot strobe.
- res_data  out  W_CTR  captured count.
- res_sat  out  1  captured count == 2^W_CTR-1.
- res_seq  out  W_SEQ  window index of res_data.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- overrun  out  1  sticky: a result was dropped.
- clr_ovr  in  1  clears overrun.
- busy  out  1  not IDLE, or capture pending.

Behaviour:
- States:
  - IDLE: ctr_rst=0, ctr_smp=0.
  - PRIME: one cycle, ctr_rst=1.
  - GATE: gate_len cycles, strobes low.
  - BOUNDARY: one cycle, ctr_smp=1 and ctr_rst=1 together.
- ctr_rst and ctr_smp are decoded from the registered state; they carry no extra register stage.
- Transitions:
  - IDLE -> PRIME when en=1.
  - PRIME -> GATE.
  - GATE -> BOUNDARY after gate_len GATE cycles.
  - BOUNDARY -> GATE if en=1, else BOUNDARY -> IDLE.
- en low during GATE does not abort: the current window completes, is captured, then the block goes IDLE (graceful stop).
- gate_len is latched on entry to PRIME and on each BOUNDARY. Changes mid-window take effect on the next window.
- Window accounting:
  - Counter counts exactly the gate_len GATE cycles.
  - The `in` pulse during the BOUNDARY cycle is lost (1-cycle dead time).
  - Period = gate_len+1 cycles.
- Capture: the cycle after BOUNDARY, ctr_val holds the snapshot. It is registered at the end of that cycle.
- Capture timing: res_valid/res_data appear 2 cycles after the BOUNDARY cycle.
- res_seq:
  - Resets to 0 on each IDLE -> PRIME.
  - Increments after every capture, including dropped ones, so gaps are visible downstream.
  - Wraps modulo 2^W_SEQ.
- Handshake:
  - Result held stable while res_valid=1 and res_ready=0.
  - res_valid clears on a cycle with res_valid && res_ready when no new capture occurs.
  - Capture with res_valid=0, or res_valid && res_ready same cycle: new result loaded, res_valid=1.
  - Capture with res_valid && !res_ready: new result discarded, old one held, overrun <= 1.
- overrun: clr_ovr clears it. If a drop and clr_ovr occur in the same cycle, set wins.
- busy: 1 in PRIME/GATE/BOUNDARY and in the capture cycle after the last BOUNDARY; 0 otherwise.
- Reset (any time, including mid-window):
  - state=IDLE.
  - res_data=0, res_sat=0, res_seq=0, res_valid=0, overrun=0, busy=0, ctr_smp=0.
  - ctr_rst forced 1 while rst=1, so the counter is cleared too.
  - A pending capture is abandoned.

Test Plan:
- W_CTR=8, gate_len=10, counter in tied high, res_ready=1 -> results of 10 every 11 cycles; res_seq 0,1,2…; res_sat=0; first res_valid exactly 2 cycles after first BOUNDARY.
- W_CTR=4, gate_len=20, in high -> res_data=15, res_sat=1 every window.
- gate_len=5, res_ready=0 for three windows -> res_data holds seq 0; overrun=1 after second capture. Then res_ready=1 -> next accepted result has res_seq=3. clr_ovr -> overrun=0.
- gate_len=0, in high -> treated as 1: res_data=1 every 2 cycles.
- en dropped mid-GATE (gate_len=8) -> window completes, one final result delivered, busy falls after capture, state IDLE. Re-assert en -> res_seq restarts at 0.
- rst pulsed mid-GATE with res_valid=1 -> next cycle all outputs at reset values, ctr_rst=1 during rst; no result from the aborted window.
